// File: rtl/arbitro_cuenta.sv
// Round-robin scheduler sharing one cuenta1 counter among N_REQ requesters.
// Grants, drives Valor/start, waits for Fin (or times out), returns Ack.
module arbitro_cuenta #(
   parameter int N_REQ   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N_REQ-1:0]   Req,
   input  logic [3*N_REQ-1:0] ValorReq,
   output logic [N_REQ-1:0]   Ack,
   output logic [3:0]         Resultado,
   output logic               Error,
   output logic               Ocupado,
   output logic [2:0]         Valor,
   output logic               start,
   input  logic [3:0]         Cuenta,
   input  logic               Fin
);

   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int TW = $clog2(TIMEOUT) + 1;
   localparam logic [IW-1:0] ULT_RST = IW'(N_REQ - 1);
   localparam logic [TW-1:0] T_LIM   = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      REPOSO = 2'd0,
      ESPERA = 2'd1,
      LIBERA = 2'd2
   } estado_t;

   estado_t          estado_q, estado_d;
   logic [IW-1:0]    ultimo_q, ultimo_d;
   logic [TW-1:0]    timer_q, timer_d;
   logic [2:0]       valor_q, valor_d;
   logic             start_q, start_d;
   logic [N_REQ-1:0] ack_q, ack_d;
   logic             error_q, error_d;
   logic [3:0]       res_q, res_d;

   logic             hay;
   logic [IW-1:0]    sel;
   logic [2:0]       sel_val;

   // ultimo doubles as the grant index: it only changes at grant time
   always_comb begin
      int c;
      c       = 0;
      hay     = 1'b0;
      sel     = ultimo_q;
      sel_val = 3'd0;
      for (int k = 1; k <= N_REQ; k++) begin
         c = int'(ultimo_q) + k;
         if (c >= N_REQ) begin
            c = c - N_REQ;
         end
         if (!hay && Req[IW'(c)]) begin
            hay = 1'b1;
            sel = IW'(c);
         end
      end
      for (int i = 0; i < N_REQ; i++) begin
         if (sel == IW'(i)) begin
            sel_val = ValorReq[3*i +: 3];
         end
      end
   end

   always_comb begin
      estado_d = estado_q;
      ultimo_d = ultimo_q;
      timer_d  = timer_q;
      valor_d  = valor_q;
      start_d  = start_q;
      ack_d    = '0;
      error_d  = 1'b0;
      res_d    = res_q;
      unique case (estado_q)
         REPOSO: begin
            if (hay) begin
               ultimo_d = sel;
               valor_d  = sel_val;
               start_d  = 1'b1;
               timer_d  = '0;
               estado_d = ESPERA;
            end
         end
         ESPERA: begin
            timer_d = timer_q + 1'b1;
            if (Fin || (timer_q == T_LIM)) begin
               for (int i = 0; i < N_REQ; i++) begin
                  ack_d[i] = (ultimo_q == IW'(i));
               end
               // Fin has priority over the timeout in the same cycle
               res_d    = Fin ? Cuenta : 4'd0;
               error_d  = !Fin;
               start_d  = 1'b0;
               estado_d = LIBERA;
            end
         end
         LIBERA: begin
            if (!Fin) begin
               estado_d = REPOSO;
            end
         end
         default: begin
            estado_d = REPOSO;
            start_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         estado_q <= REPOSO;
         ultimo_q <= ULT_RST;
         timer_q  <= '0;
         valor_q  <= 3'd0;
         start_q  <= 1'b0;
         ack_q    <= '0;
         error_q  <= 1'b0;
         res_q    <= 4'd0;
      end else begin
         estado_q <= estado_d;
         ultimo_q <= ultimo_d;
         timer_q  <= timer_d;
         valor_q  <= valor_d;
         start_q  <= start_d;
         ack_q    <= ack_d;
         error_q  <= error_d;
         res_q    <= res_d;
      end
   end

   assign Ack       = ack_q;
   assign Resultado = res_q;
   assign Error     = error_q;
   assign Valor     = valor_q;
   assign start     = start_q;
   assign Ocupado   = (estado_q == ESPERA) || (estado_q == LIBERA);

endmodule

// File: tb/tb_arbitro_cuenta.sv
// Bench for arbitro_cuenta: counter model, transaction-level reference,
// directed scenarios and randomized request traffic.
module tb_arbitro_cuenta;

   localparam int N  = 4;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic [N-1:0]  Req;
   logic [3*N-1:0] ValorReq;
   logic [N-1:0]  Ack;
   logic [3:0]    Resultado;
   logic          Error;
   logic          Ocupado;
   logic [2:0]    Valor;
   logic          start;
   logic [3:0]    Cuenta;
   logic          Fin;

   int n_chk  = 0;
   int n_fail = 0;
   int cmode  = 0;
   bit chk_en = 1'b0;

   arbitro_cuenta #(.N_REQ(N), .TIMEOUT(TO)) dut (
      .clk       (clk),
      .reset     (reset),
      .Req       (Req),
      .ValorReq  (ValorReq),
      .Ack       (Ack),
      .Resultado (Resultado),
      .Error     (Error),
      .Ocupado   (Ocupado),
      .Valor     (Valor),
      .start     (start),
      .Cuenta    (Cuenta),
      .Fin       (Fin)
   );

   always #5 clk = ~clk;

   // counter: mode 0 normal, 1 never finishes, 2 holds Fin 5 extra cycles
   int   c_cyc, c_hold;
   logic c_fin;
   assign Fin    = c_fin;
   assign Cuenta = {1'b0, Valor} + 4'd1;

   always @(posedge clk) begin
      if (reset) begin
         c_cyc  <= 0;
         c_hold <= 0;
         c_fin  <= 1'b0;
      end else if (start) begin
         c_cyc  <= c_cyc + 1;
         c_hold <= (cmode == 2) ? 5 : 0;
         if (cmode != 1 && c_cyc + 1 >= int'(Valor) + 1) c_fin <= 1'b1;
      end else begin
         c_cyc <= 0;
         if (c_hold > 0) c_hold <= c_hold - 1;
         else c_fin <= 1'b0;
      end
   end

   // reference: one operation in flight, timestamps instead of a timer
   int       n = 0;
   int       m_t0, m_ult, m_g;
   bit       m_op, m_acked, m_found;
   logic [N-1:0] m_ack;
   logic     m_err;
   logic [3:0] m_res;
   logic [2:0] m_val;

   always @(posedge clk) begin
      n++;
      m_ack = '0;
      m_err = 1'b0;
      if (reset) begin
         m_op    = 1'b0;
         m_acked = 1'b0;
         m_ult   = N - 1;
         m_val   = 3'd0;
         m_res   = 4'd0;
      end else if (!m_op) begin
         m_found = 1'b0;
         for (int k = 1; k <= N; k++) begin
            if (!m_found && Req[(m_ult + k) % N]) begin
               m_found = 1'b1;
               m_g     = (m_ult + k) % N;
            end
         end
         if (m_found) begin
            m_val   = ValorReq[3*m_g +: 3];
            m_ult   = m_g;
            m_op    = 1'b1;
            m_acked = 1'b0;
            m_t0    = n;
         end
      end else if (!m_acked) begin
         if (Fin) begin
            m_res      = {1'b0, m_val} + 4'd1;
            m_ack[m_g] = 1'b1;
            m_acked    = 1'b1;
         end else if (n - m_t0 == TO) begin
            m_res      = 4'd0;
            m_err      = 1'b1;
            m_ack[m_g] = 1'b1;
            m_acked    = 1'b1;
         end
      end else if (!Fin) begin
         m_op = 1'b0;
      end
   end

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s: got %0h expected %0h at t=%0t",
                     nm, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("m_ack", Ack, m_ack);
         chk("m_error", Error, m_err);
         chk("m_resultado", Resultado, m_res);
         chk("m_ocupado", Ocupado, m_op);
         chk("m_start", start, m_op && !m_acked);
         chk("m_valor", Valor, m_val);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic wait_ack(output int idx);
      int c;
      idx = -1;
      c   = 0;
      while (idx < 0 && c < 200) begin
         tick();
         c++;
         for (int i = 0; i < N; i++) if (Ack[i]) idx = i;
      end
      if (idx < 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL wait_ack: no Ack within 200 cycles at t=%0t", $time);
      end
   endtask

   task automatic wait_idle();
      int c;
      c = 0;
      while (Ocupado && c < 200) begin
         tick();
         c++;
      end
      chk("idle_bound", Ocupado, 1'b0);
   endtask

   initial begin
      int idx;
      reset    = 1'b1;
      Req      = '0;
      ValorReq = '0;
      @(posedge clk);
      chk_en = 1'b1;
      #1;
      tick();
      chk("rst_ocupado", Ocupado, 1'b0);
      chk("rst_start", start, 1'b0);
      chk("rst_valor", Valor, 3'd0);
      chk("rst_res", Resultado, 4'd0);
      reset = 1'b0;

      // single request, value 3
      ValorReq[2:0] = 3'd3;
      Req = 4'b0001;
      tick();
      chk("s1_start", start, 1'b1);
      chk("s1_valor", Valor, 3'd3);
      Req = 4'b0000;
      repeat (4) tick();
      chk("s1_noack", Ack, 4'b0000);
      tick();
      chk("s1_ack", Ack, 4'b0001);
      chk("s1_res", Resultado, 4'd4);
      chk("s1_err", Error, 1'b0);
      tick();
      chk("s1_ack_pulse", Ack, 4'b0000);
      chk("s1_busy", Ocupado, 1'b1);
      tick();
      chk("s1_free", Ocupado, 1'b0);

      // round-robin with all requesters held high
      do_reset();
      ValorReq = {3'd3, 3'd2, 3'd1, 3'd0};
      Req = 4'b1111;
      for (int j = 0; j < 5; j++) begin
         wait_ack(idx);
         chk("rr_idx", idx, j % 4);
         chk("rr_res", Resultado, (j % 4) + 1);
      end
      Req = 4'b0000;
      wait_idle();

      // late arrival ranks ahead of an older waiter below the pointer
      do_reset();
      ValorReq = {3'd1, 3'd4, 3'd2, 3'd3};
      Req = 4'b0100;
      tick();
      chk("la_valor", Valor, 3'd4);
      Req = 4'b0101;
      tick();
      Req = 4'b1101;
      wait_ack(idx);
      chk("la_first", idx, 2);
      Req[2] = 1'b0;
      wait_ack(idx);
      chk("la_second", idx, 3);
      Req[3] = 1'b0;
      wait_ack(idx);
      chk("la_third", idx, 0);
      Req[0] = 1'b0;
      wait_idle();

      // timeout: counter never answers
      cmode = 1;
      do_reset();
      ValorReq[5:3] = 3'd5;
      Req = 4'b0010;
      tick();
      chk("to_start", start, 1'b1);
      repeat (7) tick();
      chk("to_noack", Ack, 4'b0000);
      tick();
      chk("to_ack", Ack, 4'b0010);
      chk("to_err", Error, 1'b1);
      chk("to_res", Resultado, 4'd0);
      Req = 4'b0000;
      tick();
      chk("to_free", Ocupado, 1'b0);
      chk("to_err_pulse", Error, 1'b0);
      cmode = 0;
      ValorReq[2:0] = 3'd2;
      Req = 4'b0001;
      wait_ack(idx);
      chk("to_next_idx", idx, 0);
      chk("to_next_res", Resultado, 4'd3);
      chk("to_next_err", Error, 1'b0);
      Req = 4'b0000;
      wait_idle();

      // reset in the middle of ESPERA
      ValorReq = {3'd7, 3'd6, 3'd5, 3'd4};
      Req = 4'b0100;
      tick();
      chk("rm_valor", Valor, 3'd6);
      Req = 4'b0101;
      repeat (2) tick();
      reset = 1'b1;
      tick();
      chk("rm_start", start, 1'b0);
      chk("rm_busy", Ocupado, 1'b0);
      chk("rm_ack", Ack, 4'b0000);
      chk("rm_valor0", Valor, 3'd0);
      reset = 1'b0;
      tick();
      chk("rm_regrant", start, 1'b1);
      chk("rm_regval", Valor, 3'd4);
      wait_ack(idx);
      chk("rm_first", idx, 0);
      Req[0] = 1'b0;
      wait_ack(idx);
      chk("rm_second", idx, 2);
      Req = 4'b0000;
      wait_idle();

      // Fin stuck high after start falls
      cmode = 2;
      ValorReq[11:9] = 3'd1;
      Req = 4'b1000;
      wait_ack(idx);
      chk("fs_idx", idx, 3);
      Req = 4'b0001;
      for (int j = 0; j < 6; j++) begin
         tick();
         chk("fs_busy", Ocupado, 1'b1);
         chk("fs_nostart", start, 1'b0);
      end
      cmode = 0;
      tick();
      chk("fs_free", Ocupado, 1'b0);
      tick();
      chk("fs_grant", start, 1'b1);
      chk("fs_valor", Valor, 3'd4);
      wait_ack(idx);
      chk("fs_next", idx, 0);
      Req = 4'b0000;
      wait_idle();

      // randomized traffic checked only by the reference
      do_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (cyc % 300 == 0) begin
            if ($urandom_range(0, 9) < 7) cmode = 0;
            else cmode = $urandom_range(1, 2);
         end
         for (int i = 0; i < N; i++) begin
            if (!Req[i]) begin
               ValorReq[3*i +: 3] = 3'($urandom);
               if ($urandom_range(0, 3) == 0) Req[i] = 1'b1;
            end else if (Ack[i] && $urandom_range(0, 3) != 0) begin
               Req[i] = 1'b0;
            end
         end
         reset = ($urandom_range(0, 499) == 0);
         tick();
      end
      reset = 1'b0;
      cmode = 0;
      Req   = '0;
      wait_idle();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
